fifo_pack_reader: RTL

Read-side consumer for the team's memory-based show-ahead FIFO. It drains FIFO words through the FIFO's `rden`/`empty` read port and packs `PACK` consecutive words into one wide word. The wide word is presented on a valid/ready stream to downstream logic such as accelerator operand loaders. A `flush` request emits a partial word together with a word count.

---
 rtl/fifo_pack_reader.sv | 104 ++++++++++
 1 files changed

// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader
//   Drains a show-ahead FIFO through its rden/empty read port and packs PACK
//   consecutive words into one wide word on a valid/ready stream. The first
//   word read lands in lane 0. A single-cycle flush emits a partially filled
//   word, and m_cnt reports how many lanes are valid.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fifo_rd, fifo_empty   FIFO head word (valid when not empty), empty flag
//   fifo_rden             combinational pop; the head is consumed at that edge
//   flush                 request to emit the partial word
//   m_valid, m_ready      output stream handshake
//   m_data, m_cnt         packed word and its number of valid lanes (1..PACK)
module fifo_pack_reader #(
    parameter int DWIDTH = 8,
    parameter int PACK   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DWIDTH-1:0]         fifo_rd,
    input  logic                      fifo_empty,
    output logic                      fifo_rden,
    input  logic                      flush,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DWIDTH*PACK-1:0]    m_data,
    output logic [$clog2(PACK):0]     m_cnt
);
    localparam int CNTW = $clog2(PACK) + 1;
    localparam int IDXW = $clog2(PACK);

    logic [PACK-1:0][DWIDTH-1:0] acc_q, acc_d;
    logic [CNTW-1:0]             acc_cnt_q, acc_cnt_d;
    logic                        flush_pend_q, flush_pend_d;
    logic                        m_valid_q, m_valid_d;
    logic [DWIDTH*PACK-1:0]      m_data_q, m_data_d;
    logic [CNTW-1:0]             m_cnt_q, m_cnt_d;

    logic            acc_rdy;
    logic            xfer;
    logic            pop;
    logic [IDXW-1:0] idx;

    assign acc_rdy = (acc_cnt_q == CNTW'(PACK)) | (flush_pend_q & (acc_cnt_q != '0));
    assign xfer    = acc_rdy & (~m_valid_q | m_ready);
    // Popping into a full accumulator is only allowed when it empties this
    // cycle; rst_n gating keeps the FIFO untouched while reset is held.
    assign pop     = rst_n & ~fifo_empty & ~flush_pend_q &
                     ((acc_cnt_q < CNTW'(PACK)) | xfer);
    // A pop that coincides with a transfer starts the next group in lane 0.
    assign idx     = xfer ? '0 : acc_cnt_q[IDXW-1:0];

    always_comb begin
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        flush_pend_d = flush_pend_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_cnt_d      = m_cnt_q;

        if (xfer) begin
            // Stale lanes from an earlier group are masked, not cleared in acc.
            for (int i = 0; i < PACK; i++)
                m_data_d[i*DWIDTH +: DWIDTH] = (i < int'(acc_cnt_q)) ? acc_q[i] : '0;
            m_cnt_d      = acc_cnt_q;
            m_valid_d    = 1'b1;
            acc_cnt_d    = '0;
            flush_pend_d = 1'b0;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (pop) begin
            acc_d[idx] = fifo_rd;
            acc_cnt_d  = acc_cnt_d + CNTW'(1);
        end

        // A flush with nothing buffered (after this cycle's pop) is dropped.
        if (flush && (acc_cnt_d != '0))
            flush_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_cnt_q      <= '0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_cnt_q      <= m_cnt_d;
        end
    end

    assign fifo_rden = pop;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_cnt     = m_cnt_q;
endmodule
